// File: rtl/ps2_byte_rx.sv
// PS/2 device-to-host byte receiver: synchronizes the raw bus, frames 11-bit
// packets on ps2_clk falling edges and reports good bytes or rejected frames.
module ps2_byte_rx #(
    parameter int TIMEOUT_CYCLES = 2000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] byte_out,
    output logic       byte_valid,
    output logic       parity_err,
    output logic       frame_err,
    output logic       busy
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t           state;
    state_t           state_next;

    logic [1:0]       clk_sync;
    logic [1:0]       data_sync;
    logic             clk_prev;
    logic             fall_edge;
    logic             rx_bit;

    logic [2:0]       bit_cnt;
    logic [7:0]       shift_reg;
    logic             parity_bit;
    logic [CNT_W-1:0] idle_cnt;
    logic             timeout_hit;

    logic [7:0]       byte_next;
    logic             valid_next;
    logic             perr_next;
    logic             ferr_next;

    // Synchronizers reset to 1 so a released bus never looks like a falling edge.
    // NOTE: all clocked state uses non-blocking assignments so every flop
    // samples the pre-edge values of its neighbours.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            clk_sync  <= 2'b11;
            data_sync <= 2'b11;
            clk_prev  <= 1'b1;
        end else begin
            clk_sync  <= {clk_sync[0], ps2_clk};
            data_sync <= {data_sync[0], ps2_data};
            clk_prev  <= clk_sync[1];
        end
    end

    assign fall_edge   = clk_prev & ~clk_sync[1];
    assign rx_bit      = data_sync[1];
    // A real edge in the same cycle as the timeout keeps the frame alive.
    assign timeout_hit = (state != IDLE) && (idle_cnt == TIMEOUT_VAL) && !fall_edge;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (fall_edge && !rx_bit) begin
                    state_next = DATA;
                end
            end
            DATA: begin
                if (fall_edge && (bit_cnt == 3'd7)) begin
                    state_next = PARITY;
                end
            end
            PARITY: begin
                if (fall_edge) begin
                    state_next = STOP;
                end
            end
            STOP: begin
                if (fall_edge) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
        if (timeout_hit) begin
            state_next = IDLE;
        end
    end

    always_comb begin
        byte_next  = byte_out;
        valid_next = 1'b0;
        perr_next  = 1'b0;
        ferr_next  = 1'b0;
        if (timeout_hit) begin
            ferr_next = 1'b1;
        end else if ((state == STOP) && fall_edge) begin
            // Stop-bit errors take precedence; odd parity means an odd total of ones.
            if (!rx_bit) begin
                ferr_next = 1'b1;
            end else if (!(^{shift_reg, parity_bit})) begin
                perr_next = 1'b1;
            end else begin
                byte_next  = shift_reg;
                valid_next = 1'b1;
            end
        end
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bit_cnt    <= 3'd0;
            shift_reg  <= 8'h00;
            parity_bit <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (fall_edge && !rx_bit) begin
                        bit_cnt <= 3'd0;
                    end
                end
                DATA: begin
                    if (fall_edge) begin
                        shift_reg <= {rx_bit, shift_reg[7:1]};
                        bit_cnt   <= bit_cnt + 3'd1;
                    end
                end
                PARITY: begin
                    if (fall_edge) begin
                        parity_bit <= rx_bit;
                    end
                end
                default: ;
            endcase
        end
    end

    // Inactivity counter: restarts on every edge, saturates at the timeout value.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idle_cnt <= '0;
        end else if ((state == IDLE) || fall_edge) begin
            idle_cnt <= '0;
        end else if (idle_cnt != TIMEOUT_VAL) begin
            idle_cnt <= idle_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            byte_out   <= 8'h00;
            byte_valid <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            byte_out   <= byte_next;
            byte_valid <= valid_next;
            parity_err <= perr_next;
            frame_err  <= ferr_next;
        end
    end

endmodule

// File: tb/tb_ps2_byte_rx.sv
// Self-checking bench for ps2_byte_rx: directed frames plus random frames
// scored against a frame-level model of the PS/2 receive rules.
module tb_ps2_byte_rx;

    localparam int TB_TIMEOUT = 64;

    logic       clk;
    logic       reset;
    logic       ps2_clk;
    logic       ps2_data;
    logic [7:0] byte_out;
    logic       byte_valid;
    logic       parity_err;
    logic       frame_err;
    logic       busy;

    int vectors;
    int miscompares;

    int n_valid;
    int n_perr;
    int n_ferr;
    int n_multi;
    int n_busy;

    logic [7:0] model_byte;

    ps2_byte_rx #(.TIMEOUT_CYCLES(TB_TIMEOUT)) dut (
        .clk       (clk),
        .reset     (reset),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .byte_out  (byte_out),
        .byte_valid(byte_valid),
        .parity_err(parity_err),
        .frame_err (frame_err),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse monitor: counts every cycle each flag is seen high.
    always @(negedge clk) begin
        if (byte_valid) n_valid++;
        if (parity_err) n_perr++;
        if (frame_err) n_ferr++;
        if ((int'(byte_valid) + int'(parity_err) + int'(frame_err)) > 1) n_multi++;
        if (busy) n_busy++;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic send_bit(input logic b);
        ps2_data = b;
        repeat (4) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (8) @(negedge clk);
        ps2_clk = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    // Sends one full frame; checks the flag pulse lands exactly one cycle after
    // the stop edge is seen, lasts one cycle, and matches the model.
    task automatic send_frame(input string name, input logic [7:0] b,
                              input logic par, input logic stop);
        logic [2:0] exp_flags;
        logic [2:0] got_flags;
        int v0, p0, f0, m0;
        int dv, dp, df, dm;

        if (!stop) begin
            exp_flags = 3'b001;
        end else if (($countones(b) + int'(par)) % 2 == 0) begin
            exp_flags = 3'b010;
        end else begin
            exp_flags  = 3'b100;
            model_byte = b;
        end

        v0 = n_valid; p0 = n_perr; f0 = n_ferr; m0 = n_multi;
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(par);

        ps2_data = stop;
        repeat (4) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        got_flags = {byte_valid, parity_err, frame_err};
        vectors++;
        if (got_flags !== exp_flags) begin
            miscompares++;
            $display("FAIL %s flags_at_E+1: got %b expected %b", name, got_flags, exp_flags);
        end
        @(negedge clk);
        got_flags = {byte_valid, parity_err, frame_err};
        vectors++;
        if (got_flags !== 3'b000) begin
            miscompares++;
            $display("FAIL %s flags_at_E+2: got %b expected 000", name, got_flags);
        end
        repeat (6) @(negedge clk);
        ps2_clk = 1'b1;
        repeat (8) @(negedge clk);

        dv = n_valid - v0; dp = n_perr - p0; df = n_ferr - f0; dm = n_multi - m0;
        vectors++;
        if (dv !== int'(exp_flags[2]) || dp !== int'(exp_flags[1]) ||
            df !== int'(exp_flags[0]) || dm !== 0) begin
            miscompares++;
            $display("FAIL %s pulse_counts: valid=%0d perr=%0d ferr=%0d multi=%0d expected %0d/%0d/%0d/0",
                     name, dv, dp, df, dm, exp_flags[2], exp_flags[1], exp_flags[0]);
        end
        vectors++;
        if (byte_out !== model_byte || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL %s byte_busy: byte_out=%h busy=%b expected %h busy=0",
                     name, byte_out, busy, model_byte);
        end
    endtask

    task automatic check_all_zero(input string name);
        vectors++;
        if (byte_out !== 8'h00 || byte_valid !== 1'b0 || parity_err !== 1'b0 ||
            frame_err !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL %s outputs: byte=%h v=%b pe=%b fe=%b busy=%b expected all 0",
                     name, byte_out, byte_valid, parity_err, frame_err, busy);
        end
    endtask

    task automatic test_reset();
        reset    = 1'b0;
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        model_byte = 8'h00;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        reset = 1'b1;
        repeat (4) @(negedge clk);
        check_all_zero("after_reset");
    endtask

    task automatic test_a5();
        send_frame("frame_a5", 8'hA5, 1'b1, 1'b1);
    endtask

    task automatic test_parity_err();
        send_frame("parity_00", 8'h00, 1'b0, 1'b1);
    endtask

    task automatic test_stop_err();
        send_frame("stop_3c", 8'h3C, 1'b1, 1'b0);
    endtask

    task automatic test_timeout();
        int v0, p0, f0;
        v0 = n_valid; p0 = n_perr; f0 = n_ferr;
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'($urandom_range(0, 1)));
        vectors++;
        if (busy !== 1'b1) begin
            miscompares++;
            $display("FAIL timeout_busy_mid: got %b expected 1", busy);
        end
        ps2_data = 1'b1;
        repeat (TB_TIMEOUT + 5) @(negedge clk);
        vectors++;
        if ((n_ferr - f0) !== 1 || (n_valid - v0) !== 0 || (n_perr - p0) !== 0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL timeout_abort: ferr=%0d valid=%0d perr=%0d busy=%b expected 1/0/0/0",
                     n_ferr - f0, n_valid - v0, n_perr - p0, busy);
        end
        vectors++;
        if (byte_out !== model_byte) begin
            miscompares++;
            $display("FAIL timeout_byte_kept: got %h expected %h", byte_out, model_byte);
        end
        send_frame("after_timeout_12", 8'h12, 1'b1, 1'b1);
    endtask

    task automatic test_reset_midframe();
        send_bit(1'b0);
        for (int i = 0; i < 5; i++) send_bit(1'b1);
        @(negedge clk);
        #2 reset = 1'b0;
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        model_byte = 8'h00;
        #1 check_all_zero("reset_midframe_immediate");
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (4) @(negedge clk);
        check_all_zero("reset_midframe_released");
        send_frame("after_reset_7f", 8'h7F, 1'b0, 1'b1);
    endtask

    task automatic test_idle_one();
        int v0, p0, f0, b0;
        v0 = n_valid; p0 = n_perr; f0 = n_ferr; b0 = n_busy;
        send_bit(1'b1);
        repeat (8) @(negedge clk);
        vectors++;
        if ((n_busy - b0) !== 0 || (n_valid - v0) !== 0 || (n_perr - p0) !== 0 ||
            (n_ferr - f0) !== 0 || byte_out !== model_byte) begin
            miscompares++;
            $display("FAIL idle_one: busy_cycles=%0d v=%0d pe=%0d fe=%0d byte=%h expected 0/0/0/0 %h",
                     n_busy - b0, n_valid - v0, n_perr - p0, n_ferr - f0, byte_out, model_byte);
        end
    endtask

    task automatic test_random();
        logic [7:0] b;
        logic       par;
        logic       stop;
        for (int i = 0; i < 20; i++) begin
            b    = 8'($urandom);
            par  = (($urandom_range(0, 3) == 0) ? (^b) : ~(^b));
            stop = ($urandom_range(0, 7) != 0);
            send_frame($sformatf("random_%0d", i), b, par, stop);
        end
    endtask

    initial begin
        vectors = 0; miscompares = 0;
        n_valid = 0; n_perr = 0; n_ferr = 0; n_multi = 0; n_busy = 0;
        test_reset();
        test_a5();
        test_parity_err();
        test_stop_err();
        test_idle_one();
        test_timeout();
        test_reset_midframe();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ps2_byte_rx.md
PS2_BYTE_RX -- requirements
Module: ps2_byte_rx

Interface
REQ-001 SHALL have parameter: TIMEOUT_CYCLES, 2000, number of clk cycles with no ps2_clk falling edge after which an in-progress frame is aborted.
REQ-002 SHALL have port: clk  input  1  system clock; all state updates on its rising edge.
REQ-003 SHALL have port: reset  input  1  asynchronous, active-low reset; asserted when 0.
REQ-004 SHALL have port: ps2_clk  input  1  raw PS/2 device clock, asynchronous to clk.
REQ-005 SHALL have port: ps2_data  input  1  raw PS/2 device data, asynchronous to clk.
REQ-006 SHALL have port: byte_out  output  8  last correctly received byte; feeds the PS/2 packet framer.
REQ-007 SHALL have port: byte_valid  output  1  one-cycle pulse; byte_out is new this cycle.
REQ-008 SHALL have port: parity_err  output  1  one-cycle pulse; frame rejected for bad odd parity.
REQ-009 SHALL have port: frame_err  output  1  one-cycle pulse; frame rejected for bad stop bit or timeout.
REQ-010 SHALL have port: busy  output  1  high while a frame is in progress (state not IDLE).

Function
REQ-011 SHALL pass ps2_clk and ps2_data each through a 2-flop synchronizer; a third flop holds previous synchronized ps2_clk.
REQ-012 SHALL detect a falling edge (cycle E) when previous synchronized ps2_clk = 1 and current = 0; the bit value is synchronized ps2_data in cycle E.
REQ-013 SHALL implement states IDLE, DATA, PARITY, STOP.
REQ-014 IDLE: on edge with bit = 0 (start bit) -> DATA, bit counter = 0; on edge with bit = 1 -> stay IDLE, no output.
REQ-015 DATA: on each edge, shift bit into the shift register LSB-first and increment the counter; after the 8th bit -> PARITY.
REQ-016 PARITY: on edge, capture the parity bit -> STOP.
REQ-017 STOP: on edge -> IDLE, with outcome: stop bit = 0 -> frame_err; else the 8 data bits plus parity bit have an even count of ones -> parity_err; else byte_out <= shifted byte and byte_valid.
REQ-018 SHALL give stop-bit error precedence: frame_err only, never two flags in one cycle.
REQ-019 SHALL register all outputs: the flag pulse is high in cycle E+1 for exactly one cycle.
REQ-020 SHALL hold byte_out unchanged except on byte_valid; errors never modify byte_out.
REQ-021 SHALL keep a cycle counter in non-IDLE states, cleared on every detected edge and on entry from IDLE, saturating (no wrap).
REQ-022 When the counter reaches TIMEOUT_CYCLES in a non-IDLE state, SHALL go to IDLE and pulse frame_err next cycle; an edge in the same cycle wins and clears the counter.
REQ-023 SHALL size the counter width as clog2(TIMEOUT_CYCLES+1).
REQ-024 busy SHALL be combinational from state: 1 in DATA, PARITY, STOP.

Reset
REQ-025 While reset = 0: state IDLE, counters 0, shift register 0, byte_out 0x00, byte_valid/parity_err/frame_err 0, synchronizer flops 1 (idle bus). Effect is immediate, independent of clk.
REQ-026 Reset mid-frame SHALL discard the partial frame; the first falling edge after release with bit 0 starts a new frame.

Verification
REQ-027 Frame 0x A5: start 0, data 1,0,1,0,0,1,0,1, parity 1, stop 1 -> byte_out = 0xA5, byte_valid 1 for one cycle at E+1 of the stop edge, no error flags, busy 0 afterwards.
REQ-028 Frame 0x00 with parity 0 -> parity_err pulse once, byte_valid stays 0, byte_out keeps the previous 0xA5.
REQ-029 Frame 0x3C, parity 1, stop 0 -> frame_err pulse only; parity_err 0; byte_out unchanged.
REQ-030 Start plus 4 data bits, then ps2_clk held high for TIMEOUT_CYCLES+5 cycles -> frame_err pulse, busy 0; next full frame 0x12 (parity 1) -> byte_valid, byte_out = 0x12.
REQ-031 Reset driven to 0 after 5 data bits of a frame -> all outputs 0 immediately; after release, frame 0x7F (parity 0) -> byte_valid, byte_out = 0x7F.
REQ-032 Falling edge with ps2_data = 1 while IDLE -> busy stays 0, no flag pulses.
